// File: rtl/board_engine.sv
// board_engine: Minesweeper board state, cursor and game FSM feeding the VGA
// controller. Every cell keeps a mine bit, a visibility state and a 4-bit
// adjacency count. A safe reveal runs an 8-cycle neighbour scan before the
// cell is committed.
module board_engine #(
  parameter int FILAS    = 8,
  parameter int COLUMNAS = 8,
  localparam int RW = $clog2(FILAS),
  localparam int CW = $clog2(COLUMNAS),
  localparam int N  = FILAS * COLUMNAS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [N-1:0]  mine_map,
  output logic          load_ready,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_reveal,
  input  logic          btn_flag,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [9:0]    rd_code,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          busy,
  output logic          won,
  output logic          lost
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(N + 1);
  localparam logic [RW:0] ROWS_L = (RW+1)'(FILAS);
  localparam logic [CW:0] COLS_L = (CW+1)'(COLUMNAS);
  localparam logic [1:0] C_HID = 2'd0;
  localparam logic [1:0] C_FLG = 2'd1;
  localparam logic [1:0] C_REV = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_COUNT, S_WON, S_LOST} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] cur_row_q, cur_row_d, tgt_row_q, tgt_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d, tgt_col_q, tgt_col_d;
  logic [2:0]    k_q, k_d;
  logic [3:0]    acc_q, acc_d, acc_sum;
  logic [TW-1:0] mine_total_q, mine_total_d, safe_q, safe_d, pop;
  logic [9:0]    rd_code_q, rd_code_d;

  logic [N-1:0]       mine_vec;
  logic [N-1:0][1:0]  st_vec;
  logic [N-1:0][9:0]  code_vec;
  logic [IW-1:0]      cur_idx, tgt_idx;
  logic               restart, lose_all, flag_we, commit;

  logic signed [1:0]    dr, dc;
  logic signed [RW+1:0] nr;
  logic signed [CW+1:0] nc;
  logic                 nb_ok, nb_mine;

  function automatic logic [IW-1:0] idx_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return IW'(r) * IW'(COLUMNAS) + IW'(c);
  endfunction

  assign cur_idx = idx_of(cur_row_q, cur_col_q);
  assign tgt_idx = idx_of(tgt_row_q, tgt_col_q);

  // Neighbour k of the latched target; off-board positions never count.
  always_comb begin
    dr = 2'sb00;
    dc = 2'sb00;
    case (k_q)
      3'd0:    begin dr = -2'sd1; dc = -2'sd1; end
      3'd1:    begin dr = -2'sd1; dc =  2'sd0; end
      3'd2:    begin dr = -2'sd1; dc =  2'sd1; end
      3'd3:    begin dr =  2'sd0; dc = -2'sd1; end
      3'd4:    begin dr =  2'sd0; dc =  2'sd1; end
      3'd5:    begin dr =  2'sd1; dc = -2'sd1; end
      3'd6:    begin dr =  2'sd1; dc =  2'sd0; end
      default: begin dr =  2'sd1; dc =  2'sd1; end
    endcase
    nr = $signed({2'b00, tgt_row_q}) + $signed({{RW{dr[1]}}, dr});
    nc = $signed({2'b00, tgt_col_q}) + $signed({{CW{dc[1]}}, dc});
    nb_ok = !nr[RW+1] && !nc[CW+1] && (nr[RW:0] < ROWS_L) && (nc[CW:0] < COLS_L);
    nb_mine = nb_ok && mine_vec[idx_of(nr[RW-1:0], nc[CW-1:0])];
    acc_sum = acc_q + {3'b000, nb_mine};
  end

  // Mine count of the offered map, latched as mine_total on restart.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + TW'(mine_map[i]);
  end

  // Game FSM: load/restart, prioritised button decode, neighbour scan.
  always_comb begin
    state_d      = state_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    tgt_row_d    = tgt_row_q;
    tgt_col_d    = tgt_col_q;
    k_d          = k_q;
    acc_d        = acc_q;
    mine_total_d = mine_total_q;
    safe_d       = safe_q;
    restart      = 1'b0;
    lose_all     = 1'b0;
    flag_we      = 1'b0;
    commit       = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (btn_reveal) begin
          if (st_vec[cur_idx] == C_HID) begin
            if (mine_vec[cur_idx]) begin
              lose_all = 1'b1;
              state_d  = S_LOST;
            end else begin
              tgt_row_d = cur_row_q;
              tgt_col_d = cur_col_q;
              k_d       = 3'd0;
              acc_d     = 4'd0;
              state_d   = S_COUNT;
            end
          end
        end else if (btn_flag) begin
          flag_we = (st_vec[cur_idx] != C_REV);
        end else if (btn_up) begin
          cur_row_d = (cur_row_q == '0) ? RW'(FILAS - 1) : cur_row_q - 1'b1;
        end else if (btn_down) begin
          cur_row_d = (cur_row_q == RW'(FILAS - 1)) ? '0 : cur_row_q + 1'b1;
        end else if (btn_left) begin
          cur_col_d = (cur_col_q == '0) ? CW'(COLUMNAS - 1) : cur_col_q - 1'b1;
        end else if (btn_right) begin
          cur_col_d = (cur_col_q == CW'(COLUMNAS - 1)) ? '0 : cur_col_q + 1'b1;
        end
      end
      S_COUNT: begin
        acc_d = acc_sum;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd7) begin
          commit  = 1'b1;
          safe_d  = safe_q + TW'(1);
          state_d = (safe_q + TW'(1) == TW'(N) - mine_total_q) ? S_WON : S_PLAY;
        end
      end
      default: begin
        if (load_valid) begin
          restart      = 1'b1;
          cur_row_d    = '0;
          cur_col_d    = '0;
          mine_total_d = pop;
          safe_d       = '0;
          state_d      = S_PLAY;
        end
      end
    endcase
  end

  // FSM, cursor and scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      tgt_row_q    <= '0;
      tgt_col_q    <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      mine_total_q <= '0;
      safe_q       <= '0;
      rd_code_q    <= 10'h002;
    end else begin
      state_q      <= state_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      tgt_row_q    <= tgt_row_d;
      tgt_col_q    <= tgt_col_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      mine_total_q <= mine_total_d;
      safe_q       <= safe_d;
      rd_code_q    <= rd_code_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      logic       mine_q, mine_d;
      logic [1:0] st_q, st_d;
      logic [3:0] cnt_q, cnt_d;
      logic [9:0] code;

      // Per-cell update: restart, reveal-all-mines, flag toggle, commit.
      always_comb begin
        mine_d = mine_q;
        st_d   = st_q;
        cnt_d  = cnt_q;
        if (restart) begin
          mine_d = mine_map[gi];
          st_d   = C_HID;
          cnt_d  = 4'd0;
        end else if (lose_all) begin
          if (mine_q) st_d = C_REV;
        end else if (flag_we && cur_idx == IW'(gi)) begin
          st_d = (st_q == C_HID) ? C_FLG : C_HID;
        end else if (commit && tgt_idx == IW'(gi)) begin
          st_d  = C_REV;
          cnt_d = acc_sum;
        end
      end

      // Per-cell storage registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          mine_q <= 1'b0;
          st_q   <= C_HID;
          cnt_q  <= 4'd0;
        end else begin
          mine_q <= mine_d;
          st_q   <= st_d;
          cnt_q  <= cnt_d;
        end
      end

      // Cell code as seen by the video controller, without the cursor bit.
      always_comb begin
        code = 10'h002;
        if (st_q == C_FLG)       code = 10'h008;
        else if (st_q == C_HID)  code = mine_q ? 10'h006 : 10'h002;
        else if (mine_q)         code = 10'h004;
        else if (cnt_q == 4'd0)  code = 10'h000;
        else                     code = {cnt_q, 6'h10};
      end

      assign mine_vec[gi] = mine_q;
      assign st_vec[gi]   = st_q;
      assign code_vec[gi] = code;
    end
  endgenerate

  // Read port: pre-edge storage, cursor bit only while a game is live.
  always_comb begin
    rd_code_d = 10'h002;
    if (({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L))
      rd_code_d = code_vec[idx_of(rd_row, rd_col)];
    if ((state_q == S_PLAY || state_q == S_COUNT) && rd_row == cur_row_q && rd_col == cur_col_q)
      rd_code_d[0] = 1'b1;
  end

  assign rd_code    = rd_code_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign busy       = (state_q == S_COUNT);
  assign won        = (state_q == S_WON);
  assign lost       = (state_q == S_LOST);
  assign load_ready = (state_q == S_IDLE) || (state_q == S_WON) || (state_q == S_LOST);

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: random and directed play against a cell-level game model.
module tb_board_engine;
  localparam int FILAS = 8;
  localparam int COLUMNAS = 8;
  localparam int N = FILAS * COLUMNAS;
  localparam int HID = 0, FLG = 1, REV = 2;
  localparam int G_IDLE = 0, G_PLAY = 1, G_WON = 2, G_LOST = 3;
  localparam logic [5:0] UP = 6'b100000, DN = 6'b010000, LF = 6'b001000;
  localparam logic [5:0] RT = 6'b000100, RV = 6'b000010, FL = 6'b000001;

  logic clk = 1'b0;
  logic rst, load_valid, load_ready;
  logic [N-1:0] mine_map;
  logic btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
  logic [2:0] rd_row, rd_col, cur_row, cur_col;
  logic [9:0] rd_code;
  logic busy, won, lost;

  always #5 clk = ~clk;

  board_engine #(.FILAS(FILAS), .COLUMNAS(COLUMNAS)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .mine_map(mine_map),
    .load_ready(load_ready), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_reveal(btn_reveal),
    .btn_flag(btn_flag), .rd_row(rd_row), .rd_col(rd_col), .rd_code(rd_code),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .won(won), .lost(lost)
  );

  int checks = 0;
  int errors = 0;

  // Game model
  bit m_mine[FILAS][COLUMNAS];
  int m_st[FILAS][COLUMNAS];
  int m_cnt[FILAS][COLUMNAS];
  int m_r, m_c, m_game, m_safe, m_total;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < FILAS; r++)
      for (int c = 0; c < COLUMNAS; c++) begin
        m_mine[r][c] = 0; m_st[r][c] = HID; m_cnt[r][c] = 0;
      end
    m_r = 0; m_c = 0; m_game = G_IDLE; m_safe = 0; m_total = 0;
  endfunction

  function automatic void m_load(input logic [N-1:0] map);
    m_total = 0;
    for (int r = 0; r < FILAS; r++)
      for (int c = 0; c < COLUMNAS; c++) begin
        m_mine[r][c] = map[r*COLUMNAS+c]; m_st[r][c] = HID; m_cnt[r][c] = 0;
        if (m_mine[r][c]) m_total++;
      end
    m_r = 0; m_c = 0; m_game = G_PLAY; m_safe = 0;
  endfunction

  function automatic int m_neigh(input int r, input int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < FILAS && c+dc >= 0 && c+dc < COLUMNAS)
          if (m_mine[r+dr][c+dc]) n++;
    return n;
  endfunction

  // Applies one cycle of buttons; returns 1 when a neighbour count starts.
  function automatic bit m_act(input logic [5:0] b);
    if (m_game != G_PLAY) return 0;
    if (b[1]) begin
      if (m_st[m_r][m_c] == HID) begin
        if (!m_mine[m_r][m_c]) return 1;
        for (int r = 0; r < FILAS; r++)
          for (int c = 0; c < COLUMNAS; c++)
            if (m_mine[r][c]) m_st[r][c] = REV;
        m_game = G_LOST;
      end
    end else if (b[0]) begin
      if (m_st[m_r][m_c] == HID) m_st[m_r][m_c] = FLG;
      else if (m_st[m_r][m_c] == FLG) m_st[m_r][m_c] = HID;
    end else if (b[5]) m_r = (m_r + FILAS - 1) % FILAS;
    else if (b[4]) m_r = (m_r + 1) % FILAS;
    else if (b[3]) m_c = (m_c + COLUMNAS - 1) % COLUMNAS;
    else if (b[2]) m_c = (m_c + 1) % COLUMNAS;
    return 0;
  endfunction

  function automatic void m_commit();
    m_cnt[m_r][m_c] = m_neigh(m_r, m_c);
    m_st[m_r][m_c] = REV;
    m_safe++;
    m_game = (m_safe == N - m_total) ? G_WON : G_PLAY;
  endfunction

  function automatic logic [9:0] m_code(input int r, input int c);
    logic [9:0] v;
    if (m_st[r][c] == FLG) v = 10'h008;
    else if (m_st[r][c] == HID) v = m_mine[r][c] ? 10'h006 : 10'h002;
    else if (m_mine[r][c]) v = 10'h004;
    else if (m_cnt[r][c] == 0) v = 10'h000;
    else v = 10'(m_cnt[r][c] * 64 + 16);
    if (m_game == G_PLAY && r == m_r && c == m_c) v[0] = 1'b1;
    return v;
  endfunction

  task automatic drive_btns(input logic [5:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag} = b;
  endtask

  task automatic check_status();
    check_val("busy", busy, 0);
    check_val("cur_row", cur_row, m_r);
    check_val("cur_col", cur_col, m_c);
    check_val("won", won, m_game == G_WON);
    check_val("lost", lost, m_game == G_LOST);
    check_val("load_ready", load_ready, m_game != G_PLAY);
  endtask

  task automatic do_buttons(input logic [5:0] b, input bit noise);
    bit start;
    int cyc;
    @(negedge clk); drive_btns(b);
    @(negedge clk); drive_btns(6'b0);
    start = m_act(b);
    if (start) begin
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
        cyc++;
        if (noise) drive_btns(6'($urandom));
        @(negedge clk);
      end
      drive_btns(6'b0);
      check_val("busy_cycles", cyc, 8);
      m_commit();
    end
    check_status();
    $display("btn=%b count=%0d cur=(%0d,%0d) game=%0d", b, start, m_r, m_c, m_game);
  endtask

  task automatic read_cell(input int r, input int c, output logic [9:0] code);
    @(negedge clk); rd_row = 3'(r); rd_col = 3'(c);
    @(negedge clk); code = rd_code;
  endtask

  task automatic compare_all(input string tag);
    logic [9:0] code;
    for (int r = 0; r < FILAS; r++)
      for (int c = 0; c < COLUMNAS; c++) begin
        read_cell(r, c, code);
        check_val($sformatf("%s_cell_%0d_%0d", tag, r, c), code, m_code(r, c));
      end
    $display("board compare %s done", tag);
  endtask

  task automatic load_map(input logic [N-1:0] map);
    bit acc;
    acc = (m_game != G_PLAY);
    @(negedge clk); load_valid = 1'b1; mine_map = map;
    @(negedge clk); load_valid = 1'b0;
    if (acc) m_load(map);
    check_status();
    $display("load map=%h accepted=%0d", map, acc);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    $display("reset");
  endtask

  task automatic move_to(input int r, input int c);
    int g = 0;
    while (m_r != r && g < 20) begin do_buttons(DN, 0); g++; end
    while (m_c != c && g < 40) begin do_buttons(RT, 0); g++; end
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] map;
    logic [9:0] code;
    int dens;
    rst = 1'b1; load_valid = 1'b0; mine_map = '0; rd_row = '0; rd_col = '0;
    drive_btns(6'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Reset state
    check_status();
    compare_all("reset");

    // Single mine at (0,1), reveal (0,0)
    map = '0; map[1] = 1'b1;
    load_map(map);
    do_buttons(RV, 0);
    read_cell(0, 0, code); check_val("count1_cursor", code, 10'h051);
    read_cell(0, 1, code); check_val("hidden_mine", code, 10'h006);

    // Wrap moves and reveal-over-flag priority
    do_buttons(UP, 0);
    do_buttons(LF, 0);
    do_buttons(RV | FL, 0);
    read_cell(7, 7, code); check_val("reveal_beats_flag", code, 10'h001);

    // Flag blocks reveal, flag toggles back
    move_to(3, 3);
    do_buttons(FL, 0);
    read_cell(3, 3, code); check_val("flag_cursor", code, 10'h009);
    do_buttons(RV, 0);
    read_cell(3, 3, code); check_val("flag_blocks_reveal", code, 10'h009);
    do_buttons(FL, 0);
    read_cell(3, 3, code); check_val("unflag_cursor", code, 10'h003);
    compare_all("flags");

    // Lose with a flagged mine
    do_reset();
    map = '0; map[2*COLUMNAS+2] = 1'b1; map[5*COLUMNAS+5] = 1'b1;
    load_map(map);
    move_to(5, 5);
    do_buttons(FL, 0);
    move_to(2, 2);
    do_buttons(RV, 0);
    read_cell(2, 2, code); check_val("lost_mine_22", code, 10'h004);
    read_cell(5, 5, code); check_val("lost_mine_55", code, 10'h004);
    for (int i = 0; i < 4; i++) do_buttons(6'($urandom), 0);
    compare_all("lost");

    // All-mine map: any reveal loses
    map = '1;
    load_map(map);
    do_buttons(RV, 0);

    // Random games
    for (int g = 0; g < 6; g++) begin
      if (m_game == G_PLAY) do_reset();
      dens = $urandom_range(5, 30);
      for (int i = 0; i < N; i++) map[i] = ($urandom % 100) < dens;
      load_map(map);
      for (int a = 0; a < 80 && m_game == G_PLAY; a++) begin
        logic [5:0] b;
        b[5] = ($urandom % 4) == 0; b[4] = ($urandom % 4) == 0;
        b[3] = ($urandom % 4) == 0; b[2] = ($urandom % 4) == 0;
        b[1] = ($urandom % 4) == 0; b[0] = ($urandom % 6) == 0;
        if (($urandom % 25) == 0) load_map(map ^ 64'($urandom));
        do_buttons(b, 1);
      end
      compare_all($sformatf("game%0d", g));
    end

    // Win by revealing all 63 safe cells
    if (m_game == G_PLAY) do_reset();
    map = '0; map[N-1] = 1'b1;
    load_map(map);
    for (int r = 0; r < FILAS; r++)
      for (int c = 0; c < COLUMNAS; c++)
        if (!(r == FILAS-1 && c == COLUMNAS-1)) begin
          move_to(r, c);
          do_buttons(RV, 0);
        end
    check_val("won_final", won, 1);
    read_cell(6, 6, code); check_val("corner_66", code, 10'h050);

    // Reset in the middle of a neighbour count
    map = '0; map[0] = 1'b1;
    load_map(map);
    do_buttons(RT, 0);
    @(negedge clk); btn_reveal = 1'b1;
    @(negedge clk); btn_reveal = 1'b0;
    repeat (3) @(negedge clk);
    check_val("busy_mid_count", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
    check_status();
    read_cell(0, 1, code); check_val("abort_no_commit", code, 10'h002);
    check_val("abort_model", code, m_code(0, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
